instr_encoder: RTL
==================

# instr_encoder

Encodes a stream of symbolic instruction requests (kind plus register and immediate fields) into 32-bit MIPS machine words for the supported subset. It buffers the words in a small FIFO and emits them with sequential word addresses to an instruction-memory write port. It is the producer side of the instruction controller: every word it emits must decode back to the same kind and fields. Used by the bench and program-loader paths to fill instruction memory before the core runs.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- ADDR_W, 10: word-address width of the IM write port
- BASE_ADDR, 0: first word address after reset or flush
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; empties the FIFO, returns address to BASE_ADDR, clears illegal
- in_valid  input  1  request present
- in_ready  output  1  request accepted on a cycle where in_valid & in_ready
- in_kind  input  4  1 addu, 2 subu, 3 ori, 4 lw, 5 sw, 6 beq, 7 lui, 8 jal, 9 jr; others illegal
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  16  immediate or branch offset
- in_target  input  26  jal target field
- out_valid  output  1  IM write pending
- out_ready  input  1  IM accepts the write on a cycle where out_valid & out_ready
- im_addr  output  ADDR_W  word address of the pending write
- im_wdata  output  32  encoded word
- illegal  output  1  sticky; an illegal kind was accepted
- count  output  log2(DEPTH)+1  FIFO occupancy

## Operation
- Encoding rules:
  - addu: rs, rt and rd fields, shamt 0, funct 0x21.
  - subu: rs, rt and rd fields, shamt 0, funct 0x23.
  - jr: op 0, rs field, rt, rd and shamt 0, funct 0x08.
  - ori 0x0D, lw 0x23, sw 0x2B, beq 0x04: op, rs, rt, imm.
  - lui 0x0F: rs field forced to 0.
  - jal 0x03: target field.
  - Fields unused by a kind are ignored.
- Encoding is combinational on the input. The encoded word is pushed into the FIFO on acceptance.
- Illegal kind: the request is accepted (handshake completes), nothing is pushed, and illegal is set.
- in_ready = !full & !flush. It does not depend on out_ready; there is no pass-through when full.
- Push and pop in the same cycle: both take effect and count is unchanged.
- On every pop, im_addr increments by 1, modulo 2^ADDR_W; it wraps from all-ones to 0.
- im_wdata is the FIFO head while out_valid = 1, and 0 otherwise.
- Flush priority: flush overrides push and pop in its cycle. No IM write completes in the flush cycle, even if out_ready = 1.
- Reset mid-stream: all buffered words are discarded.

## Timing
- Reset values:
  - in_ready 1, out_valid 0, im_addr BASE_ADDR, im_wdata 0, illegal 0, count 0.
  - The FIFO storage array is not reset.
- Latency: a word accepted at edge N gives out_valid = 1 after edge N, i.e. visible in cycle N+1.
- Throughput: one word per cycle in steady state when out_ready is held at 1.
- Output stability: while out_valid = 1 and out_ready = 0, im_addr and im_wdata hold stable.
- Full: when count = DEPTH, in_ready = 0 in that same cycle.
- Empty: out_valid = 0 and im_wdata = 0.
- After flush: count = 0, out_valid = 0, and im_addr = BASE_ADDR on the next cycle.

## Structure
- Shared package (also used by the decoder side) holds:
  - kind codes 1–9 as named constants;
  - opcode constants: 0x00, 0x0D, 0x23, 0x2B, 0x04, 0x0F, 0x03;
  - funct constants: 0x21, 0x23, 0x08.
- Sub-module sync_fifo (DEPTH × 32, count output, registered pointers):
  - no pass-through;
  - write ignored when full, read ignored when empty.
- Top-level contents: the encoder mux, the address counter and the illegal flag.

## Test plan
- Single-word encodings with out_ready = 1:
  - addu rs=1 rt=2 rd=3 → im_wdata 0x00221821 at im_addr 0, one cycle after acceptance.
  - ori rt=5 imm=0x1234 → 0x34051234.
  - lui rs=7 rt=8 imm=0xFFFF → 0x3C08FFFF; the rs field is ignored.
- Back-to-back stream with out_ready = 1: jal target=0xC03, jr rs=31, beq rs=1 rt=2 imm=0xFFFF, sw rt=4 imm=8 → 0x0C000C03, 0x03E00008, 0x1022FFFF, 0xAC040008 at consecutive addresses 0–3, one per cycle.
- Backpressure: out_ready = 0 while sending DEPTH+1 requests → in_ready drops after 4 accepted, count = 4, im_addr and im_wdata stay stable. Releasing out_ready drains in order, and the 5th request is accepted after the first pop.
- Illegal kind 0 and kind 12 → both accepted, count unchanged, illegal = 1 until flush. The next valid word uses the unchanged address.
- Address wrap with ADDR_W = 2: 5 words → addresses 0, 1, 2, 3, 0.
- Disruption cases:
  - flush with 3 words buffered and in_valid = 1 → nothing accepted, count = 0 and im_addr = 0 next cycle.
  - reset asserted mid-stream → all outputs immediately take their reset values.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and its matching decoder.
// Holds the request kind codes, the MIPS opcode and funct values for the
// supported subset, and a helper that tells whether a kind code is supported.
package instr_encoder_pkg;

  // Request kind codes
  localparam logic [3:0] KIND_ADDU = 4'd1;
  localparam logic [3:0] KIND_SUBU = 4'd2;
  localparam logic [3:0] KIND_ORI  = 4'd3;
  localparam logic [3:0] KIND_LW   = 4'd4;
  localparam logic [3:0] KIND_SW   = 4'd5;
  localparam logic [3:0] KIND_BEQ  = 4'd6;
  localparam logic [3:0] KIND_LUI  = 4'd7;
  localparam logic [3:0] KIND_JAL  = 4'd8;
  localparam logic [3:0] KIND_JR   = 4'd9;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  function automatic logic kind_is_legal(input logic [3:0] kind);
    return (kind >= KIND_ADDU) && (kind <= KIND_JR);
  endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// sync_fifo: DEPTH x WIDTH synchronous FIFO with registered pointers and an
// occupancy count. No pass-through: a word written this cycle is readable
// from the next cycle. Writes while full and reads while empty are ignored.
// clear empties the FIFO and overrides any write or read in the same cycle.
// Storage is not reset; only the pointers and count are.
// Ports: clk, reset (async, active-low), clear, wr_en, wr_data, rd_en,
//        rd_data (head word), full, empty, count.
module sync_fifo
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full && !clear;
  assign do_rd   = rd_en && !empty && !clear;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic instruction requests into 32-bit MIPS words,
// buffers them in a sync_fifo and writes them to instruction memory at
// sequential word addresses starting from BASE_ADDR.
// Ports:
//   clk, reset (async, active-low), flush (sync: empty FIFO, rewind address,
//   clear illegal)
//   in_valid/in_ready, in_kind, in_rs, in_rt, in_rd, in_imm, in_target: request
//   out_valid/out_ready, im_addr, im_wdata: IM write port
//   illegal: sticky flag, an unsupported kind was accepted
//   count: FIFO occupancy
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_kind,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        im_addr,
  output logic [31:0]              im_wdata,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0] enc_word;
  logic [31:0] head;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  // Encoder mux: purely combinational on the request fields.
  always_comb begin
    enc_word = '0;
    case (in_kind)
      KIND_ADDU: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FUNCT_ADDU};
      KIND_SUBU: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FUNCT_SUBU};
      KIND_ORI:  enc_word = {OP_ORI, in_rs, in_rt, in_imm};
      KIND_LW:   enc_word = {OP_LW,  in_rs, in_rt, in_imm};
      KIND_SW:   enc_word = {OP_SW,  in_rs, in_rt, in_imm};
      KIND_BEQ:  enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
      KIND_LUI:  enc_word = {OP_LUI, 5'd0, in_rt, in_imm};
      KIND_JAL:  enc_word = {OP_JAL, in_target};
      KIND_JR:   enc_word = {OP_RTYPE, in_rs, 15'd0, FUNCT_JR};
      default:   enc_word = '0;
    endcase
  end

  assign legal     = kind_is_legal(in_kind);
  // Readiness ignores out_ready: a full FIFO never passes a word straight through.
  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  // Illegal kinds complete the handshake but never occupy a FIFO slot.
  assign push      = accept && legal;
  assign out_valid = !empty;
  // No IM write completes in a flush cycle.
  assign pop       = out_valid && out_ready && !flush;
  assign im_wdata  = out_valid ? head : '0;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (push),
    .wr_data (enc_word),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Word address advances once per completed IM write and wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_addr <= BASE;
    end else if (flush) begin
      im_addr <= BASE;
    end else if (pop) begin
      im_addr <= im_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else if (flush) begin
      illegal <= 1'b0;
    end else if (accept && !legal) begin
      illegal <= 1'b1;
    end
  end

endmodule
